// File: rtl/dc_offset_cal.sv
// DC-offset calibrator: settle, average 2^AVG_LOG2 valid samples per channel, then subtract the held offset.
// Optional: define DC_OFFSET_SAT_EN to saturate the corrected output instead of wrapping it.
module dc_offset_cal #(
  parameter int NCH           = 4,
  parameter int W             = 16,
  parameter int SETTLE_CYCLES = 40960,
  parameter int AVG_LOG2      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [NCH*W-1:0] in_data,
  output logic             out_valid,
  output logic [NCH*W-1:0] out_data,
  output logic [NCH*W-1:0] offset,
  output logic             busy,
  output logic             cal_done,
  output logic [1:0]       dbg_state
);

  // in_valid qualifies in_data on every posedge; there is no backpressure.
  // out_valid qualifies out_data one cycle later; out_data holds while out_valid is low.
  localparam int AW  = W + AVG_LOG2;
  localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int NW  = AVG_LOG2 + 1;
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [NW-1:0]  SAMPLE_LAST = NW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACCUM, S_HOLD} state_t;

  state_t           state, state_nx;
  logic [SCW-1:0]   settle_cnt;
  logic [NW-1:0]    sample_cnt;
  logic [NCH*AW-1:0] acc, acc_nx;
  logic [NCH*W-1:0] off_nx, corr;
  logic             settle_done, last_sample;

  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign last_sample = in_valid && (sample_cnt == SAMPLE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = S_SETTLE;
    end else begin
      case (state)
        S_SETTLE: if (settle_done) state_nx = S_ACCUM;
        S_ACCUM:  if (last_sample) state_nx = S_HOLD;
        default:  state_nx = state;
      endcase
    end
  end

  always_comb begin
    busy      = (state == S_SETTLE) || (state == S_ACCUM);
    cal_done  = (state == S_HOLD);
    dbg_state = state;
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic signed [W-1:0]  samp_k, off_k;
    logic signed [AW-1:0] acc_k, sum_k;
    assign samp_k = in_data[k*W +: W];
    assign off_k  = offset[k*W +: W];
    assign acc_k  = acc[k*AW +: AW];
    assign sum_k  = acc_k + AW'(samp_k);
    assign acc_nx[k*AW +: AW] = sum_k;
    // Arithmetic shift floors toward -inf; the mean of W-bit samples always fits in W bits.
    assign off_nx[k*W +: W]   = W'(sum_k >>> AVG_LOG2);
`ifdef DC_OFFSET_SAT_EN
    logic signed [W:0] diff_k;
    assign diff_k = (W+1)'(samp_k) - (W+1)'(off_k);
    assign corr[k*W +: W] = (diff_k[W] != diff_k[W-1]) ?
                            {diff_k[W], {(W-1){~diff_k[W]}}} : diff_k[W-1:0];
`else
    assign corr[k*W +: W] = samp_k - off_k;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
      sample_cnt <= '0;
      acc        <= '0;
      offset     <= '0;
    end else if (start) begin
      settle_cnt <= '0;
      sample_cnt <= '0;
      acc        <= '0;
      offset     <= '0;
    end else begin
      if (state == S_SETTLE && !settle_done) settle_cnt <= settle_cnt + 1'b1;
      if (state == S_ACCUM && in_valid) begin
        if (last_sample) begin
          offset <= off_nx;
        end else begin
          acc        <= acc_nx;
          sample_cnt <= sample_cnt + 1'b1;
        end
      end
    end
  end

  // Correction uses the offset registered before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out_data <= corr;
    end
  end

endmodule

// File: tb/tb_dc_offset_cal.sv
// Randomized self-checking bench for dc_offset_cal (NCH=2, W=16, SETTLE_CYCLES=16, AVG_LOG2=2).
module tb_dc_offset_cal;
  localparam int NCH = 2;
  localparam int W = 16;
  localparam int SETTLE = 16;
  localparam int AVG_LOG2 = 2;
  localparam int NAVG = 1 << AVG_LOG2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [NCH*W-1:0] in_data = '0;
  logic out_valid;
  logic [NCH*W-1:0] out_data, offset;
  logic busy, cal_done;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;
  int exp_off0 = 0, exp_off1 = 0;
  logic [NCH*W-1:0] exp_last = '0;
  logic [NCH*W-1:0] exp_q[$];
  int src0[$], src1[$];

  dc_offset_cal #(.NCH(NCH), .W(W), .SETTLE_CYCLES(SETTLE), .AVG_LOG2(AVG_LOG2)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .offset(offset),
    .busy(busy), .cal_done(cal_done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  function automatic int floor_avg(input int s);
    if (s >= 0) return s / NAVG;
    return -((-s + NAVG - 1) / NAVG);
  endfunction

  function automatic logic [W-1:0] red(input int diff);
    int x;
    x = diff;
`ifdef DC_OFFSET_SAT_EN
    if (x > 32767) x = 32767;
    if (x < -32768) x = -32768;
`endif
    return x[W-1:0];
  endfunction

  task automatic drive_cycle(input bit v, input int d0, input int d1, input bit st);
    in_valid = v;
    in_data  = {d1[W-1:0], d0[W-1:0]};
    start    = st;
    if (v) exp_last = {red(d1 - exp_off1), red(d0 - exp_off0)};
    exp_q.push_back(exp_last);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || offset !== '0 || busy !== 1'b0 || cal_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got ov=%b od=%h off=%h busy=%b done=%b want all zero",
               out_valid, out_data, offset, busy, cal_done);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Full calibration from a start pulse; returns early after abort_after accepted samples (if >= 0).
  task automatic run_cal(input int gap_pct, input int abort_after);
    int d0, d1, n, s0, s1, guard;
    bit v;
    logic [NCH*W-1:0] e;
    d0 = rnd16(); d1 = rnd16();
    drive_cycle(1'b1, d0, d1, 1'b1);
    exp_off0 = 0; exp_off1 = 0;
    e = exp_q.pop_front();
    checks++;
    if (out_data !== e || out_valid !== 1'b1) begin
      errors++; $display("FAIL start_out: got %h want %h", out_data, e);
    end
    checks++;
    if (busy !== 1'b1 || cal_done !== 1'b0 || offset !== '0) begin
      errors++; $display("FAIL start_flags: got busy=%b done=%b off=%h want 1 0 0", busy, cal_done, offset);
    end
    for (int i = 0; i < SETTLE; i++) begin
      v = 1'($urandom_range(0, 1));
      drive_cycle(v, rnd16(), rnd16(), 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (out_data !== e || out_valid !== v) begin
        errors++; $display("FAIL settle_out: got %h/%b want %h/%b", out_data, out_valid, e, v);
      end
      checks++;
      if (busy !== 1'b1 || cal_done !== 1'b0 || offset !== '0) begin
        errors++; $display("FAIL settle_flags: got busy=%b done=%b off=%h want 1 0 0", busy, cal_done, offset);
      end
    end
    n = 0; s0 = 0; s1 = 0; guard = 0;
    while (n < NAVG && guard < 400) begin
      guard++;
      v = ($urandom_range(0, 99) >= gap_pct);
      d0 = (v && src0.size() > 0) ? src0.pop_front() : rnd16();
      d1 = (v && src1.size() > 0) ? src1.pop_front() : rnd16();
      drive_cycle(v, d0, d1, 1'b0);
      if (v) begin n++; s0 += d0; s1 += d1; end
      if (n == NAVG) begin exp_off0 = floor_avg(s0); exp_off1 = floor_avg(s1); end
      e = exp_q.pop_front();
      checks++;
      if (out_data !== e || out_valid !== v) begin
        errors++; $display("FAIL accum_out: got %h/%b want %h/%b", out_data, out_valid, e, v);
      end
      checks++;
      if (busy !== (n < NAVG) || cal_done !== (n == NAVG) || offset !== {W'(exp_off1), W'(exp_off0)}) begin
        errors++;
        $display("FAIL accum_flags: got busy=%b done=%b off=%h want %b %b %h", busy, cal_done, offset,
                 (n < NAVG), (n == NAVG), {W'(exp_off1), W'(exp_off0)});
      end
      if (n == abort_after) return;
    end
    if (n < NAVG) begin
      checks++; errors++;
      $display("FAIL accum_budget: got %0d samples want %0d", n, NAVG);
    end
  endtask

  task automatic run_hold(input int cycles);
    bit v;
    logic [NCH*W-1:0] e;
    for (int i = 0; i < cycles; i++) begin
      v = 1'($urandom_range(0, 1));
      drive_cycle(v, rnd16(), rnd16(), 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (out_data !== e || out_valid !== v || busy !== 1'b0 || cal_done !== 1'b1 ||
          offset !== {W'(exp_off1), W'(exp_off0)}) begin
        errors++;
        $display("FAIL hold: got od=%h ov=%b busy=%b done=%b off=%h want od=%h ov=%b off=%h",
                 out_data, out_valid, busy, cal_done, offset, e, v, {W'(exp_off1), W'(exp_off0)});
      end
    end
  endtask

  task automatic test_basic;
    logic [NCH*W-1:0] e;
    src0 = {100, 100, 100, 100};
    src1 = {-50, -50, -50, -50};
    run_cal(0, -1);
    checks++;
    if (offset !== {16'hFFCE, 16'h0064}) begin
      errors++; $display("FAIL basic_offset: got %h want ffce0064", offset);
    end
    drive_cycle(1'b1, 100, -50, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (out_data !== '0 || out_data !== e) begin
      errors++; $display("FAIL basic_zero_out: got %h want 00000000", out_data);
    end
    run_hold(10);
  endtask

  task automatic test_floor_gaps;
    src0 = {-3, -2, -2, -2};
    run_cal(60, -1);
    checks++;
    if (offset[W-1:0] !== 16'hFFFD) begin
      errors++; $display("FAIL floor_offset: got %h want fffd", offset[W-1:0]);
    end
    run_hold(6);
    repeat (3) begin
      run_cal(30, -1);
      run_hold(8);
    end
  endtask

  task automatic test_corners;
    logic [NCH*W-1:0] e;
    src0 = {-32768, -32768, -32768, -32768};
    run_cal(0, -1);
    drive_cycle(1'b1, 32767, 0, 1'b0);
    e = exp_q.pop_front();
    checks++;
`ifdef DC_OFFSET_SAT_EN
    if (out_data[W-1:0] !== 16'h7FFF || out_data !== e) begin
      errors++; $display("FAIL corner_pos: got %h want 7fff", out_data[W-1:0]);
    end
`else
    if (out_data[W-1:0] !== 16'hFFFF || out_data !== e) begin
      errors++; $display("FAIL corner_pos: got %h want ffff", out_data[W-1:0]);
    end
`endif
    src0 = {32767, 32767, 32767, 32767};
    run_cal(0, -1);
    drive_cycle(1'b1, -32768, 0, 1'b0);
    e = exp_q.pop_front();
    checks++;
`ifdef DC_OFFSET_SAT_EN
    if (out_data[W-1:0] !== 16'h8000 || out_data !== e) begin
      errors++; $display("FAIL corner_neg: got %h want 8000", out_data[W-1:0]);
    end
`else
    if (out_data[W-1:0] !== 16'h0001 || out_data !== e) begin
      errors++; $display("FAIL corner_neg: got %h want 0001", out_data[W-1:0]);
    end
`endif
    run_hold(4);
  endtask

  task automatic test_restart;
    run_cal(20, 2);
    run_cal(20, -1);
    run_hold(4);
    // Abort after 3 samples: the next start cycle carries the 4th valid sample and must win.
    run_cal(0, 3);
    run_cal(0, -1);
    run_hold(4);
    run_cal(10, -1);
  endtask

  task automatic test_async_reset;
    bit v;
    logic [NCH*W-1:0] e;
    drive_cycle(1'b1, rnd16(), rnd16(), 1'b1);
    exp_off0 = 0; exp_off1 = 0;
    repeat (5) drive_cycle(1'b1, rnd16(), rnd16(), 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || offset !== '0 || busy !== 1'b0 || cal_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got ov=%b od=%h off=%h busy=%b done=%b want all zero",
               out_valid, out_data, offset, busy, cal_done);
    end
    #1 rst = 1'b0;
    exp_q.delete();
    exp_last = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 30; i++) begin
      v = 1'($urandom_range(0, 1));
      drive_cycle(v, rnd16(), rnd16(), 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (out_data !== e || out_valid !== v || busy !== 1'b0 || cal_done !== 1'b0 || offset !== '0) begin
        errors++;
        $display("FAIL idle_after_reset: got od=%h ov=%b busy=%b done=%b off=%h want od=%h ov=%b idle",
                 out_data, out_valid, busy, cal_done, offset, e, v);
      end
    end
    run_cal(25, -1);
    run_hold(4);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_floor_gaps();
    test_corners();
    test_restart();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
